reservation_station: RTL
========================

# reservation_station

Issue-side buffer for one arithmetic functional unit in the Tomasulo datapath. Holds up to `NUM_ENTRIES` decoded instructions with operand values or pending producer tags, snoops the common data bus (CDB) to resolve pending operands, and dispatches ready instructions one at a time to the functional unit. Each dispatch is tagged with the entry's station tag; the entry is freed when the functional unit reports `done` with that tag.

## Interface
- `NUM_ENTRIES`, 3: station entries; `TAG_BASE + NUM_ENTRIES - 1` ≤ 7.
- `TAG_BASE`, 1: tag of entry 0; entry i tag = `TAG_BASE + i`. Tag 0 is never assigned.

- `clock` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: issue request this cycle.
- `issue_ready` out 1: a free entry exists (combinational from registered state).
- `issue_tag` out 3: tag of the entry the next accepted issue will occupy (lowest free index).
- `issue_instruction` in 16: opcode word; `[3:0]` selects the operation (0000 add, 0001 sub).
- `issue_vj`, `issue_vk` in 16: operand values, used when not pending.
- `issue_qj`, `issue_qk` in 3: producer tags for pending operands.
- `issue_qj_pend`, `issue_qk_pend` in 1: operand awaits its producer tag.
- `cdb_valid` in 1: CDB broadcast this cycle.
- `cdb_tag` in 3, `cdb_data` in 16: broadcast tag and value.
- `fu_instructIn` out 1: dispatch strobe to functional unit.
- `fu_instruction` out 16, `fu_reg1` out 16, `fu_reg2` out 16: dispatched opcode and operands (`vj`, `vk`).
- `fu_code` out 3: tag of dispatched entry.
- `fu_done` in 1, `fu_code_ret` in 3: functional unit completion flag and returned tag. `fu_done` may remain high indefinitely.

## Operation
- Entry state: `busy`, `inflight`, `instr[15:0]`, `vj`, `vk`, `qj`, `qk`, `qj_pend`, `qk_pend`.
- Issue: accepted on a rising edge when `issue_valid && issue_ready`. The lowest-index free entry is loaded and `busy` is set. `issue_valid` while not ready is ignored (no entry modified).
- Snoop: on every edge with `cdb_valid`, each busy entry with `qj_pend && qj == cdb_tag` loads `vj <= cdb_data` and clears `qj_pend`. The k operand is handled identically.
- Issue/CDB bypass: if an operand being issued is pending on `cdb_tag` while `cdb_valid` is high in the same cycle, it is stored as resolved with `cdb_data`.
- Ready entry: `busy && !inflight && !qj_pend && !qk_pend`, evaluated on registered state. The lowest-index ready entry wins.
- FSM states:
  - IDLE → ISSUE when any entry is ready. On that edge, `fu_*` outputs are registered from the winner, `fu_instructIn <= 1`, and the winner's `inflight` is set.
  - ISSUE → WAIT unconditionally. On that edge, `fu_instructIn <= 0`. `fu_done` is ignored in ISSUE; a sticky `done` from the prior op must not complete the new one.
  - WAIT → IDLE on an edge with `fu_done && fu_code_ret == fu_code`. On that edge, the matching entry's `busy` and `inflight` are cleared.
  - WAIT: a mismatched `fu_code_ret` is ignored; the FSM stays in WAIT.
- Simultaneous issue and completion: the issue uses a different free entry. The freed entry appears in `issue_ready`/`issue_tag` from the next cycle.
- One instruction in flight at most; no reordering beyond lowest-index selection.

## Timing
- Reset (`reset_n` low): immediately all entries cleared, FSM = IDLE, all `fu_*` outputs = 0, `issue_ready` = 0. After release, `issue_ready` = 1 and `issue_tag` = `TAG_BASE`.
- Reset mid-operation: a pending dispatch is abandoned and `fu_instructIn` drops asynchronously. The stale FU `done`/code is harmless because of the ISSUE-state masking.
- Edge numbering for an instruction with both operands ready:
  - Issue accepted at edge E.
  - `fu_instructIn` high from edge E+1 to E+2; the functional unit latches at E+2.
  - Completion sampled at edge E+3 at the earliest; entry reusable from E+3.
- A pending operand resolved by the CDB at edge C makes the entry eligible for dispatch at edge C+1.
- Throughput: one dispatch per 3 cycles with an ideal one-cycle functional unit.

## Test plan
- Reset then single issue: `vj`=5, `vk`=3, op 0000, both ready. At edge E+1, `fu_instructIn`=1, `fu_reg1`=5, `fu_reg2`=3, `fu_code`=1. Model FU returns done with code 1, and entry 0 frees at E+3.
- Pending operand: issue op 0001, `qj`=6 pending, `vk`=4. No dispatch until CDB `tag`=6 / `data`=20; dispatch follows on the next edge with `fu_reg1`=20, `fu_reg2`=4.
- Bypass: issue with `qk`=5 pending while the CDB broadcasts `tag`=5 / `data`=0x00FF in the same cycle. Dispatch at E+1 with `fu_reg2`=0x00FF.
- Full: three issues, all pending on tag 7. `issue_ready`=0, and a fourth `issue_valid` changes nothing. A CDB broadcast of tag 7 dispatches tags 1, 2, 3 in order, 3 cycles apart.
- Sticky done: hold `fu_done`=1 with `fu_code_ret`=1 throughout. The second instruction (tag 2) does not free until `fu_code_ret`=2.
- Mid-WAIT reset: pulse `reset_n` low while in WAIT. `fu_instructIn`=0 and `issue_ready`=0 immediately; after release, `issue_tag`=1 and a fresh issue dispatches normally.

Source files
------------

// File: rtl/reservation_station_if.sv
// Issue, CDB snoop and functional-unit dispatch signals of one reservation station.
// The station itself uses the slave view; whoever feeds it (decode, CDB, FU) uses master.
interface reservation_station_if;
  // issue side
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_tag;
  logic [15:0] issue_instruction;
  logic [15:0] issue_vj;
  logic [15:0] issue_vk;
  logic [2:0]  issue_qj;
  logic [2:0]  issue_qk;
  logic        issue_qj_pend;
  logic        issue_qk_pend;
  // common data bus
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  // functional unit
  logic        fu_instructIn;
  logic [15:0] fu_instruction;
  logic [15:0] fu_reg1;
  logic [15:0] fu_reg2;
  logic [2:0]  fu_code;
  logic        fu_done;
  logic [2:0]  fu_code_ret;

  modport slave (
    input  issue_valid, issue_instruction, issue_vj, issue_vk,
           issue_qj, issue_qk, issue_qj_pend, issue_qk_pend,
           cdb_valid, cdb_tag, cdb_data, fu_done, fu_code_ret,
    output issue_ready, issue_tag,
           fu_instructIn, fu_instruction, fu_reg1, fu_reg2, fu_code
  );

  modport master (
    output issue_valid, issue_instruction, issue_vj, issue_vk,
           issue_qj, issue_qk, issue_qj_pend, issue_qk_pend,
           cdb_valid, cdb_tag, cdb_data, fu_done, fu_code_ret,
    input  issue_ready, issue_tag,
           fu_instructIn, fu_instruction, fu_reg1, fu_reg2, fu_code
  );
endinterface

// File: rtl/reservation_station.sv
// Reservation station for one arithmetic functional unit (Tomasulo issue buffer).
// Entries wait for operands by snooping the CDB; ready entries are dispatched one at
// a time (lowest index first) and freed when the FU returns done with the entry's tag.
module reservation_station #(
  parameter int NUM_ENTRIES = 3,
  parameter int TAG_BASE    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  reservation_station_if.slave bus
);
  localparam int         IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [2:0] TAG0  = 3'(TAG_BASE);

  // IDLE: looking for a ready entry; ISSUE: strobe cycle; WAIT: awaiting FU done
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t r_state, w_state_next;

  // entry storage
  logic [NUM_ENTRIES-1:0] r_busy, r_inflight, r_qj_pend, r_qk_pend;
  logic [15:0]            r_instr [NUM_ENTRIES];
  logic [15:0]            r_vj    [NUM_ENTRIES];
  logic [15:0]            r_vk    [NUM_ENTRIES];
  logic [2:0]             r_qj    [NUM_ENTRIES];
  logic [2:0]             r_qk    [NUM_ENTRIES];

  // registered dispatch outputs
  logic        r_fu_instructIn;
  logic [15:0] r_fu_instruction, r_fu_reg1, r_fu_reg2;
  logic [2:0]  r_fu_code;

  logic [NUM_ENTRIES-1:0] w_free, w_ready, w_issue_sel, w_dispatch_sel, w_complete_sel;
  logic [NUM_ENTRIES-1:0] w_snoop_j, w_snoop_k;
  logic                   w_any_free, w_any_ready;
  logic [IDX_W-1:0]       w_free_idx, w_ready_idx;
  logic                   w_issue_accept, w_dispatch, w_complete;
  logic                   w_bypass_j, w_bypass_k;

  // An operand being issued that the CDB is broadcasting right now is captured directly.
  assign w_bypass_j     = bus.cdb_valid && bus.issue_qj_pend && (bus.issue_qj == bus.cdb_tag);
  assign w_bypass_k     = bus.cdb_valid && bus.issue_qk_pend && (bus.issue_qk == bus.cdb_tag);
  assign w_issue_accept = bus.issue_valid && w_any_free;

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
    localparam logic [2:0] TAG = 3'(TAG_BASE + gi);
    assign w_free[gi]         = !r_busy[gi];
    assign w_ready[gi]        = r_busy[gi] && !r_inflight[gi] && !r_qj_pend[gi] && !r_qk_pend[gi];
    assign w_issue_sel[gi]    = w_issue_accept && (w_free_idx == IDX_W'(gi));
    assign w_dispatch_sel[gi] = w_dispatch && (w_ready_idx == IDX_W'(gi));
    assign w_complete_sel[gi] = w_complete && (r_fu_code == TAG);
    assign w_snoop_j[gi]      = bus.cdb_valid && r_busy[gi] && r_qj_pend[gi] && (r_qj[gi] == bus.cdb_tag);
    assign w_snoop_k[gi]      = bus.cdb_valid && r_busy[gi] && r_qk_pend[gi] && (r_qk[gi] == bus.cdb_tag);
  end

  // Lowest-index free entry (for issue) and lowest-index ready entry (for dispatch).
  always_comb begin
    w_any_free  = 1'b0;
    w_any_ready = 1'b0;
    w_free_idx  = '0;
    w_ready_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_free[i]) begin
        w_any_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (w_ready[i]) begin
        w_any_ready = 1'b1;
        w_ready_idx = IDX_W'(i);
      end
    end
  end

  // Dispatch FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next state; done is only honoured in WAIT so a sticky done cannot retire a fresh op.
  always_comb begin
    w_state_next = r_state;
    w_dispatch   = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_ready) begin
          w_state_next = S_ISSUE;
          w_dispatch   = 1'b1;
        end
      end
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT: begin
        if (bus.fu_done && (bus.fu_code_ret == r_fu_code)) begin
          w_state_next = S_IDLE;
          w_complete   = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Entry update: issue load (with CDB bypass), operand snoop, inflight marking, retire.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy     <= '0;
      r_inflight <= '0;
      r_qj_pend  <= '0;
      r_qk_pend  <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_instr[i] <= '0;
        r_vj[i]    <= '0;
        r_vk[i]    <= '0;
        r_qj[i]    <= '0;
        r_qk[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_issue_sel[i]) begin
          r_busy[i]     <= 1'b1;
          r_inflight[i] <= 1'b0;
          r_instr[i]    <= bus.issue_instruction;
          r_qj[i]       <= bus.issue_qj;
          r_qk[i]       <= bus.issue_qk;
          r_vj[i]       <= w_bypass_j ? bus.cdb_data : bus.issue_vj;
          r_vk[i]       <= w_bypass_k ? bus.cdb_data : bus.issue_vk;
          r_qj_pend[i]  <= bus.issue_qj_pend && !w_bypass_j;
          r_qk_pend[i]  <= bus.issue_qk_pend && !w_bypass_k;
        end else begin
          if (w_snoop_j[i]) begin
            r_vj[i]      <= bus.cdb_data;
            r_qj_pend[i] <= 1'b0;
          end
          if (w_snoop_k[i]) begin
            r_vk[i]      <= bus.cdb_data;
            r_qk_pend[i] <= 1'b0;
          end
          if (w_dispatch_sel[i]) r_inflight[i] <= 1'b1;
          if (w_complete_sel[i]) begin
            r_busy[i]     <= 1'b0;
            r_inflight[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Dispatch output registers: load from the winner, strobe for exactly one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fu_instructIn  <= 1'b0;
      r_fu_instruction <= '0;
      r_fu_reg1        <= '0;
      r_fu_reg2        <= '0;
      r_fu_code        <= '0;
    end else if (w_dispatch) begin
      r_fu_instructIn  <= 1'b1;
      r_fu_instruction <= r_instr[w_ready_idx];
      r_fu_reg1        <= r_vj[w_ready_idx];
      r_fu_reg2        <= r_vk[w_ready_idx];
      r_fu_code        <= TAG0 + 3'(w_ready_idx);
    end else if (r_state == S_ISSUE) begin
      r_fu_instructIn  <= 1'b0;
    end
  end

  // issue_ready is forced low while reset is asserted.
  assign bus.issue_ready    = w_any_free && reset_n;
  assign bus.issue_tag      = TAG0 + 3'(w_free_idx);
  assign bus.fu_instructIn  = r_fu_instructIn;
  assign bus.fu_instruction = r_fu_instruction;
  assign bus.fu_reg1        = r_fu_reg1;
  assign bus.fu_reg2        = r_fu_reg2;
  assign bus.fu_code        = r_fu_code;
endmodule
